// File: rtl/exe_pipe_ctrl_if.sv
// ID/EXE/multicycle status in, stall/flush/PC-select/trap controls out.
// The mc_abort_o watchdog output exists only when EXE_PIPE_CTRL_MC_TIMEOUT_EN is defined.
interface exe_pipe_ctrl_if;
  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic       id_use_rs1_i;
  logic       id_use_rs2_i;
  logic       ex_valid_i;
  logic [4:0] ex_rd_i;
  logic       ex_is_load_i;
  logic       ex_br_j_taken_i;
  logic       ex_inst_addr_mis_i;
  logic       mc_start_i;
  logic       mc_done_i;
  logic       mem_stall_i;

  logic       if_stall_o;
  logic       id_stall_o;
  logic       ex_stall_o;
  logic       id_flush_o;
  logic       ex_flush_o;
  logic [1:0] pc_sel_o;
  logic       trap_o;
  logic       mc_busy_o;
`ifdef EXE_PIPE_CTRL_MC_TIMEOUT_EN
  logic       mc_abort_o;
`endif

  // Pipeline side: supplies stage status, consumes controls.
  modport master (
    output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
    output ex_valid_i, ex_rd_i, ex_is_load_i, ex_br_j_taken_i, ex_inst_addr_mis_i,
    output mc_start_i, mc_done_i, mem_stall_i,
    input  if_stall_o, id_stall_o, ex_stall_o, id_flush_o, ex_flush_o,
    input  pc_sel_o, trap_o, mc_busy_o
`ifdef EXE_PIPE_CTRL_MC_TIMEOUT_EN
    , input mc_abort_o
`endif
  );

  // Sequencer side.
  modport slave (
    input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
    input  ex_valid_i, ex_rd_i, ex_is_load_i, ex_br_j_taken_i, ex_inst_addr_mis_i,
    input  mc_start_i, mc_done_i, mem_stall_i,
    output if_stall_o, id_stall_o, ex_stall_o, id_flush_o, ex_flush_o,
    output pc_sel_o, trap_o, mc_busy_o
`ifdef EXE_PIPE_CTRL_MC_TIMEOUT_EN
    , output mc_abort_o
`endif
  );
endinterface

// File: rtl/exe_pipe_ctrl.sv
// EXE-stage pipeline sequencer: hazards, branch redirect, multicycle waits, trap drain.
// Optional multicycle watchdog enabled by defining EXE_PIPE_CTRL_MC_TIMEOUT_EN.
module exe_pipe_ctrl #(
  parameter int unsigned MC_TIMEOUT  = 64,
  parameter int unsigned TRAP_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  exe_pipe_ctrl_if.slave  bus
);
  localparam int unsigned CNT_MAX = (MC_TIMEOUT > TRAP_CYCLES) ? MC_TIMEOUT : TRAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] MC_WAIT = 2'd1;
  localparam logic [1:0] TRAP    = 2'd2;

  localparam logic [1:0] PC_SEQ  = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_TRAP = 2'd2;

  localparam logic [CNT_W-1:0] TRAP_LOAD = CNT_W'(TRAP_CYCLES - 1);
`ifdef EXE_PIPE_CTRL_MC_TIMEOUT_EN
  localparam logic [CNT_W-1:0] MC_LAST = CNT_W'(MC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       if_stall_c, id_stall_c, ex_stall_c;
  logic       id_flush_c, ex_flush_c;
  logic [1:0] pc_sel_c;
  logic       trap_c, mc_busy_c;
  logic       load_use_c;
`ifdef EXE_PIPE_CTRL_MC_TIMEOUT_EN
  logic       mc_abort_c;
`endif

  // Load in EXE feeding a register the ID instruction actually reads.
  always_comb begin
    load_use_c = bus.ex_valid_i & bus.ex_is_load_i & (bus.ex_rd_i != 5'd0) &
                 ((bus.id_use_rs1_i & (bus.id_rs1_i == bus.ex_rd_i)) |
                  (bus.id_use_rs2_i & (bus.id_rs2_i == bus.ex_rd_i)));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and raw controls; RUN conditions are evaluated in priority order.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    if_stall_c = 1'b0;
    id_stall_c = 1'b0;
    ex_stall_c = 1'b0;
    id_flush_c = 1'b0;
    ex_flush_c = 1'b0;
    pc_sel_c   = PC_SEQ;
    trap_c     = 1'b0;
    mc_busy_c  = 1'b0;
`ifdef EXE_PIPE_CTRL_MC_TIMEOUT_EN
    mc_abort_c = 1'b0;
`endif

    case (state_q)
      RUN: begin
        if (bus.ex_valid_i & bus.ex_inst_addr_mis_i) begin
          trap_c     = 1'b1;
          pc_sel_c   = PC_TRAP;
          id_flush_c = 1'b1;
          ex_flush_c = 1'b1;
          state_d    = TRAP;
          cnt_d      = TRAP_LOAD;
        end else if (bus.mem_stall_i) begin
          if_stall_c = 1'b1;
          id_stall_c = 1'b1;
          ex_stall_c = 1'b1;
        end else if (bus.ex_valid_i & bus.ex_br_j_taken_i) begin
          pc_sel_c   = PC_BR;
          id_flush_c = 1'b1;
          ex_flush_c = 1'b1;
        end else if (bus.ex_valid_i & bus.mc_start_i & ~bus.mc_done_i) begin
          if_stall_c = 1'b1;
          id_stall_c = 1'b1;
          ex_stall_c = 1'b1;
          state_d    = MC_WAIT;
          cnt_d      = '0;
        end else if (bus.ex_valid_i & bus.mc_start_i & bus.mc_done_i) begin
          state_d    = RUN;
        end else if (load_use_c) begin
          if_stall_c = 1'b1;
          id_stall_c = 1'b1;
          ex_flush_c = 1'b1;
        end
      end

      MC_WAIT: begin
        mc_busy_c = 1'b1;
`ifdef EXE_PIPE_CTRL_MC_TIMEOUT_EN
        if (~bus.mc_done_i && (cnt_q == MC_LAST)) begin
          trap_c     = 1'b1;
          mc_abort_c = 1'b1;
          pc_sel_c   = PC_TRAP;
          id_flush_c = 1'b1;
          ex_flush_c = 1'b1;
          state_d    = TRAP;
          cnt_d      = TRAP_LOAD;
        end else
`endif
        if (~bus.mc_done_i) begin
          if_stall_c = 1'b1;
          id_stall_c = 1'b1;
          ex_stall_c = 1'b1;
`ifdef EXE_PIPE_CTRL_MC_TIMEOUT_EN
          cnt_d      = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
`endif
        end else begin
          // Result arrives: release unless the data bus is still holding us.
          if_stall_c = bus.mem_stall_i;
          id_stall_c = bus.mem_stall_i;
          ex_stall_c = bus.mem_stall_i;
          state_d    = RUN;
        end
      end

      TRAP: begin
        if_stall_c = 1'b1;
        id_stall_c = 1'b1;
        ex_stall_c = 1'b1;
        id_flush_c = 1'b1;
        ex_flush_c = 1'b1;
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Controls are forced low for as long as reset is held.
  always_comb begin
    bus.if_stall_o = if_stall_c & ~rst_i;
    bus.id_stall_o = id_stall_c & ~rst_i;
    bus.ex_stall_o = ex_stall_c & ~rst_i;
    bus.id_flush_o = id_flush_c & ~rst_i;
    bus.ex_flush_o = ex_flush_c & ~rst_i;
    bus.pc_sel_o   = rst_i ? PC_SEQ : pc_sel_c;
    bus.trap_o     = trap_c & ~rst_i;
    bus.mc_busy_o  = mc_busy_c & ~rst_i;
`ifdef EXE_PIPE_CTRL_MC_TIMEOUT_EN
    bus.mc_abort_o = mc_abort_c & ~rst_i;
`endif
  end
endmodule

// File: tb/tb_exe_pipe_ctrl.sv
// Scoreboard bench for exe_pipe_ctrl; watchdog scenario runs when EXE_PIPE_CTRL_MC_TIMEOUT_EN is defined.
module tb_exe_pipe_ctrl;
  // Stimulus flag bits: exv, ld, tk, mis, mcs, mcd, mst
  localparam logic [6:0] EXV = 7'b1000000;
  localparam logic [6:0] LD  = 7'b0100000;
  localparam logic [6:0] TK  = 7'b0010000;
  localparam logic [6:0] MIS = 7'b0001000;
  localparam logic [6:0] MCS = 7'b0000100;
  localparam logic [6:0] MCD = 7'b0000010;
  localparam logic [6:0] MST = 7'b0000001;

  // Output vector: ifs ids exs idf exf pc[1:0] trap busy abort
  localparam logic [9:0] Z      = 10'b0000000000;
  localparam logic [9:0] STALL3 = 10'b1110000000;
  localparam logic [9:0] BUB    = 10'b1100100000;
  localparam logic [9:0] BR     = 10'b0001101000;
  localparam logic [9:0] TRP    = 10'b0001110100;
  localparam logic [9:0] HOLD   = 10'b1111100000;
  localparam logic [9:0] MCW    = 10'b1110000010;
  localparam logic [9:0] MCREL  = 10'b0000000010;
  localparam logic [9:0] TMO    = 10'b0001110111;

  typedef struct packed {
    logic       rst;
    logic [6:0] flags;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
  } stim_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [9:0] sb[$];

  exe_pipe_ctrl_if bus();

  exe_pipe_ctrl #(.MC_TIMEOUT(8), .TRAP_CYCLES(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t s(input logic [6:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic u1, input logic [4:0] rs2, input logic u2,
                              input logic r = 1'b0);
    stim_t x;
    x.rst = r; x.flags = f; x.rd = rd; x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2;
    return x;
  endfunction

  function automatic stim_t idle();
    return s(7'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endfunction

  function automatic logic [9:0] outs();
    logic ab;
`ifdef EXE_PIPE_CTRL_MC_TIMEOUT_EN
    ab = bus.mc_abort_o;
`else
    ab = 1'b0;
`endif
    return {bus.if_stall_o, bus.id_stall_o, bus.ex_stall_o, bus.id_flush_o, bus.ex_flush_o,
            bus.pc_sel_o, bus.trap_o, bus.mc_busy_o, ab};
  endfunction

  task automatic drive(input stim_t x);
    rst                    = x.rst;
    bus.ex_valid_i         = x.flags[6];
    bus.ex_is_load_i       = x.flags[5];
    bus.ex_br_j_taken_i    = x.flags[4];
    bus.ex_inst_addr_mis_i = x.flags[3];
    bus.mc_start_i         = x.flags[2];
    bus.mc_done_i          = x.flags[1];
    bus.mem_stall_i        = x.flags[0];
    bus.ex_rd_i            = x.rd;
    bus.id_rs1_i           = x.rs1;
    bus.id_use_rs1_i       = x.u1;
    bus.id_rs2_i           = x.rs2;
    bus.id_use_rs2_i       = x.u2;
  endtask

  task automatic test_reset();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] obs_v, exp_v;
    st.push_back(s(EXV|MIS|LD, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1)); ex.push_back(Z);
    st.push_back(s(EXV|MCS|MST, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1)); ex.push_back(Z);
    st.push_back(idle());                                          ex.push_back(Z);
    foreach (st[i]) begin
      @(posedge clk); #1; drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk); exp_v = sb.pop_front(); obs_v = outs(); checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL reset step %0d: got %b expected %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] obs_v, exp_v;
    st.push_back(s(EXV|LD, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0));  ex.push_back(BUB);
    st.push_back(idle());                                   ex.push_back(Z);
    st.push_back(s(EXV|LD, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0));  ex.push_back(Z);
    st.push_back(s(EXV|LD, 5'd7, 5'd1, 1'b1, 5'd7, 1'b1));  ex.push_back(BUB);
    st.push_back(s(EXV|LD, 5'd7, 5'd7, 1'b0, 5'd7, 1'b0));  ex.push_back(Z);
    st.push_back(s(LD, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0));      ex.push_back(Z);
    st.push_back(s(EXV, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0));     ex.push_back(Z);
    foreach (st[i]) begin
      @(posedge clk); #1; drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk); exp_v = sb.pop_front(); obs_v = outs(); checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL load_use step %0d: got %b expected %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_branch();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] obs_v, exp_v;
    st.push_back(s(EXV|TK, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0)); ex.push_back(BR);
    st.push_back(idle());                                  ex.push_back(Z);
    st.push_back(s(TK, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));     ex.push_back(Z);
    foreach (st[i]) begin
      @(posedge clk); #1; drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk); exp_v = sb.pop_front(); obs_v = outs(); checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL branch step %0d: got %b expected %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_trap();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] obs_v, exp_v;
    st.push_back(s(EXV|MIS, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));     ex.push_back(TRP);
    st.push_back(s(EXV|MIS|TK, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));  ex.push_back(HOLD);
    st.push_back(s(EXV|MCS|MST, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0)); ex.push_back(HOLD);
    st.push_back(idle());                                       ex.push_back(Z);
    st.push_back(s(MIS, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));         ex.push_back(Z);
    foreach (st[i]) begin
      @(posedge clk); #1; drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk); exp_v = sb.pop_front(); obs_v = outs(); checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL trap step %0d: got %b expected %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_multicycle();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] obs_v, exp_v;
    st.push_back(s(EXV|MCS, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));     ex.push_back(STALL3);
    st.push_back(idle());                                       ex.push_back(MCW);
    st.push_back(s(EXV|MCS, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));     ex.push_back(MCW);
    st.push_back(s(EXV|TK, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));      ex.push_back(MCW);
    st.push_back(idle());                                       ex.push_back(MCW);
    st.push_back(s(MCD, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));         ex.push_back(MCREL);
    st.push_back(idle());                                       ex.push_back(Z);
    st.push_back(s(EXV|MCS|MCD, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0)); ex.push_back(Z);
    st.push_back(idle());                                       ex.push_back(Z);
    st.push_back(s(EXV|MCS, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));     ex.push_back(STALL3);
    st.push_back(s(MCD|MST, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));     ex.push_back(MCW);
    st.push_back(idle());                                       ex.push_back(Z);
    foreach (st[i]) begin
      @(posedge clk); #1; drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk); exp_v = sb.pop_front(); obs_v = outs(); checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL multicycle step %0d: got %b expected %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_priority();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] obs_v, exp_v;
    st.push_back(s(EXV|MIS|MST|LD|TK, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0)); ex.push_back(TRP);
    st.push_back(idle());                                              ex.push_back(HOLD);
    st.push_back(idle());                                              ex.push_back(HOLD);
    st.push_back(s(EXV|TK|MST, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));         ex.push_back(STALL3);
    st.push_back(s(EXV|TK|MST, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));         ex.push_back(STALL3);
    st.push_back(s(EXV|TK, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));             ex.push_back(BR);
    st.push_back(s(EXV|MCS|MST, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));        ex.push_back(STALL3);
    st.push_back(idle());                                              ex.push_back(Z);
    st.push_back(s(EXV|TK|LD, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0));          ex.push_back(BR);
    st.push_back(s(EXV|MCS|LD, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0));         ex.push_back(STALL3);
    st.push_back(s(MCD, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));                ex.push_back(MCREL);
    st.push_back(s(EXV|MCS|MCD|LD, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0));     ex.push_back(Z);
    foreach (st[i]) begin
      @(posedge clk); #1; drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk); exp_v = sb.pop_front(); obs_v = outs(); checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL priority step %0d: got %b expected %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] obs_v, exp_v;
    st.push_back(s(EXV|MCS, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));     ex.push_back(STALL3);
    st.push_back(idle());                                       ex.push_back(MCW);
    st.push_back(idle());                                       ex.push_back(MCW);
    st.push_back(s(7'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1));  ex.push_back(Z);
    st.push_back(idle());                                       ex.push_back(Z);
    st.push_back(s(EXV|MCS, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));     ex.push_back(STALL3);
    st.push_back(s(MCD, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));         ex.push_back(MCREL);
    st.push_back(idle());                                       ex.push_back(Z);
    foreach (st[i]) begin
      @(posedge clk); #1; drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk); exp_v = sb.pop_front(); obs_v = outs(); checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL reset_mid step %0d: got %b expected %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] obs_v, exp_v;
    st.push_back(s(EXV|TK, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));     ex.push_back(BR);
    st.push_back(s(EXV|TK, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));     ex.push_back(BR);
    st.push_back(s(EXV|LD, 5'd2, 5'd0, 1'b0, 5'd2, 1'b1));     ex.push_back(BUB);
    st.push_back(s(EXV|TK, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));     ex.push_back(BR);
    st.push_back(s(EXV|MIS, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));    ex.push_back(TRP);
    st.push_back(s(EXV|MIS, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));    ex.push_back(HOLD);
    st.push_back(s(EXV|MIS, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));    ex.push_back(HOLD);
    st.push_back(s(EXV|MIS, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0));    ex.push_back(TRP);
    st.push_back(idle());                                      ex.push_back(HOLD);
    st.push_back(idle());                                      ex.push_back(HOLD);
    st.push_back(idle());                                      ex.push_back(Z);
    foreach (st[i]) begin
      @(posedge clk); #1; drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk); exp_v = sb.pop_front(); obs_v = outs(); checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL back_to_back step %0d: got %b expected %b", i, obs_v, exp_v);
      end
    end
  endtask

`ifdef EXE_PIPE_CTRL_MC_TIMEOUT_EN
  task automatic test_timeout();
    stim_t st[$]; logic [9:0] ex[$]; logic [9:0] obs_v, exp_v;
    st.push_back(s(EXV|MCS, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0)); ex.push_back(STALL3);
    for (int k = 0; k < 7; k++) begin
      st.push_back(idle()); ex.push_back(MCW);
    end
    st.push_back(idle()); ex.push_back(TMO);
    st.push_back(idle()); ex.push_back(HOLD);
    st.push_back(idle()); ex.push_back(HOLD);
    st.push_back(idle()); ex.push_back(Z);
    foreach (st[i]) begin
      @(posedge clk); #1; drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk); exp_v = sb.pop_front(); obs_v = outs(); checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL timeout step %0d: got %b expected %b", i, obs_v, exp_v);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(s(7'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1));
    test_reset();
    test_load_use();
    test_branch();
    test_trap();
    test_multicycle();
    test_priority();
    test_reset_mid();
    test_back_to_back();
`ifdef EXE_PIPE_CTRL_MC_TIMEOUT_EN
    test_timeout();
`endif
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exe_pipe_ctrl.md
Name: exe_pipe_ctrl

Overview:
- Pipeline sequencer for the execution stage of the 5-stage RV32 core.
- Consumes EXE results (branch/jump taken, instruction-address-misaligned), ID operand usage and multicycle-unit handshake.
- Drives per-stage stall and flush, PC source select and trap entry.
- Owns a small FSM for multicycle-op waits and trap-entry drain.

Parameters:
MC_TIMEOUT  64  cycles MC_WAIT may last before watchdog trap (only with macro); must be >= 2
TRAP_CYCLES  2  cycles the pipe is held in TRAP (CSR/mtvec settle); must be >= 1

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
id_rs1_i  in  5  rs1 of instruction in ID
id_rs2_i  in  5  rs2 of instruction in ID
id_use_rs1_i  in  1  ID instruction reads rs1
id_use_rs2_i  in  1  ID instruction reads rs2
ex_valid_i  in  1  EXE holds a valid instruction
ex_rd_i  in  5  rd of EXE instruction
ex_is_load_i  in  1  EXE instruction is a load
ex_br_j_taken_i  in  1  branch/jal/jalr taken, misalign-qualified
ex_inst_addr_mis_i  in  1  target address misaligned
mc_start_i  in  1  EXE issues a multicycle op this cycle
mc_done_i  in  1  multicycle result valid
mem_stall_i  in  1  data bus not ready
if_stall_o  out  1  hold PC and IF/ID
id_stall_o  out  1  hold ID/EX inputs
ex_stall_o  out  1  hold EX/MEM inputs
id_flush_o  out  1  bubble into IF/ID
ex_flush_o  out  1  bubble into ID/EX
pc_sel_o  out  2  0 sequential, 1 branch target, 2 trap vector
trap_o  out  1  one-cycle trap-entry pulse
mc_busy_o  out  1  FSM in MC_WAIT

Behaviour:
- States RUN, MC_WAIT, TRAP; 2-bit state reg plus counter, both async-reset to RUN/0.
- Outputs combinational from state and inputs; while rst_i=1 all outputs 0.
- Load-use hazard H = ex_valid_i & ex_is_load_i & ex_rd_i!=0 & ((id_use_rs1_i & id_rs1_i==ex_rd_i) | (id_use_rs2_i & id_rs2_i==ex_rd_i)).
- RUN, first match wins:
  1. ex_valid_i & ex_inst_addr_mis_i: trap_o=1, pc_sel_o=2, id_flush_o=ex_flush_o=1; next TRAP, cnt=TRAP_CYCLES-1.
  2. mem_stall_i: if/id/ex stall=1; stay RUN.
  3. ex_valid_i & ex_br_j_taken_i: pc_sel_o=1, id_flush_o=ex_flush_o=1; stay RUN. Zero-cycle penalty beyond the two flushed slots.
  4. ex_valid_i & mc_start_i & !mc_done_i: if/id/ex stall=1; next MC_WAIT, cnt=0.
  5. ex_valid_i & mc_start_i & mc_done_i: single-cycle op, no stall.
  6. H: if_stall_o=id_stall_o=1, ex_flush_o=1; stay RUN (one bubble).
  7. Otherwise all 0, pc_sel_o=0.
- MC_WAIT:
  - mc_busy_o=1; all stalls=1 while !mc_done_i; cnt increments, saturating.
  - mc_done_i: stalls released that cycle (if mem_stall_i=0); next RUN.
  - mc_start_i ignored in MC_WAIT.
- TRAP:
  - All stalls=1, id_flush_o=ex_flush_o=1, pc_sel_o=0, trap_o=0.
  - cnt decrements; cnt==0 -> RUN.
  - Branch, load, mc and mem inputs ignored.
- Simultaneous events:
  - Misalign and taken cannot both be 1 (taken is qualified); if both, trap wins.
  - Trap and mem_stall_i together: trap wins; memory side discards the faulting slot.
- Reset mid-operation: any state -> RUN, cnt=0, mc_busy_o falls with rst_i; the multicycle unit is reset by the same rst_i.

Optional Feature:
EXE_PIPE_CTRL_MC_TIMEOUT_EN
- Defined: in MC_WAIT, if cnt==MC_TIMEOUT-1 and !mc_done_i, behave as RUN rule 1 (trap_o pulse, pc_sel_o=2, flushes) and go to TRAP.
  - Adds output mc_abort_o (1 bit), asserted that same cycle.
- Undefined: no watchdog, MC_WAIT waits indefinitely, mc_abort_o absent.
  - cnt is used only by TRAP.

Test Plan:
- Load-use: ex load rd=5, ID rs1=5 use=1 -> one cycle if_stall=id_stall=1, ex_flush=1; next cycle all 0. Same with rd=0 -> no stall.
- Taken branch, ex_valid=1, taken=1 -> pc_sel=1, id_flush=ex_flush=1 for one cycle; state stays RUN.
- Misaligned jalr, ex_valid=1, mis=1 -> trap_o=1 and pc_sel=2 for one cycle; then TRAP_CYCLES=2 cycles all stalls+flushes; then RUN.
- Multicycle: mc_start=1, done 5 cycles later -> mc_busy=1 and stalls=1 for 5 cycles; release on the done cycle. mc_start&mc_done same cycle -> no stall.
- Priority: mis=1, mem_stall=1, H=1 together -> trap response only. mem_stall=1, taken=1 -> stall only, no flush until mem_stall=0.
- Reset in MC_WAIT (cycle 3) -> outputs 0 immediately, RUN after release. With macro and MC_TIMEOUT=8, no done -> trap_o and mc_abort_o on 8th MC_WAIT cycle.
